gate_sweep_checker: RTL and testbench



---
 rtl/gate_sweep_checker.sv | 162 ++++++++++++++++
 tb/tb_gate_sweep_checker.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: drives every input vector of an N_IN-input gate in
// ascending order, holds each for SETTLE cycles, then compares the gate
// output against the TRUTH table and accumulates the results.
// Optional build macro SWEEP_LOG_EN adds simulation-only per-vector logging
// and has no effect on any register.
//
// state  | meaning
// IDLE   | waiting for start; results of the last sweep held
// WAIT   | stim applied, settle counter running down
// CHECK  | one cycle: compare y with TRUTH[stim], step or finish
// DONE   | one cycle: done pulse, pass updated, busy dropped on exit
module gate_sweep_checker #(
  parameter int                      N_IN   = 2,
  parameter logic [(2**N_IN)-1:0]    TRUTH  = 4'b0001,
  parameter int                      SETTLE = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            y,
  output logic [N_IN-1:0] stim,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            fail_valid,
  output logic [N_IN-1:0] fail_vec
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Counter only needs to hold SETTLE-1; keep at least one bit.
  localparam int              CW        = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   CNT_LOAD  = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] STIM_LAST = '1;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N_IN-1:0] stim_q, stim_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [N_IN:0]   err_q, err_d;
  logic            fail_valid_q, fail_valid_d;
  logic [N_IN-1:0] fail_vec_q, fail_vec_d;

  logic            expected;
  logic            mismatch;
  logic [N_IN:0]   err_next;

  // Compare the gate output with the table; an unknown y takes the else path
  // of the equality test and is therefore counted as a mismatch.
  always_comb begin
    expected = TRUTH[stim_q];
    mismatch = 1'b1;
    if (y == expected) mismatch = 1'b0;
    err_next = err_q + {{N_IN{1'b0}}, mismatch};
  end

  // Next-state and result update logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    stim_d       = stim_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d        = '0;
          fail_valid_d = 1'b0;
          fail_vec_d   = '0;
          pass_d       = 1'b0;
          stim_d       = '0;
          cnt_d        = CNT_LOAD;
          busy_d       = 1'b1;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_CHECK;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_CHECK: begin
        err_d = err_next;
        if (mismatch && !fail_valid_q) begin
          fail_vec_d   = stim_q;
          fail_valid_d = 1'b1;
        end
        if (stim_q == STIM_LAST) begin
          done_d  = 1'b1;
          pass_d  = (err_next == '0);
          state_d = S_DONE;
        end else begin
          stim_d  = stim_q + 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous reset to the idle, cleared condition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      stim_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      stim_q       <= stim_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
    end
  end

  assign stim       = stim_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;

`ifdef SWEEP_LOG_EN
  // Simulation-only trace of each comparison and of the sweep summary.
  always @(posedge clk) begin
    if (!reset && state_q == S_CHECK) begin
      $display("%0t gate_sweep: stim=%b y=%b expected=%b", $time, stim_q, y, expected);
      if (mismatch)
        $error("%0t gate_sweep: stim=%b y=%b expected=%b", $time, stim_q, y, expected);
    end
    if (!reset && state_q == S_DONE)
      $display("%0t gate_sweep: sweep complete, err_count=%0d", $time, err_q);
  end
`else
`endif

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench for gate_sweep_checker: a 2-input instance (SETTLE=2) driven
// by a selectable gate model, and a 3-input NOR instance with SETTLE=1.
module tb_gate_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start_a, start_b;
  logic       y_a, y_b;
  logic       y_x;
  int         mode;

  logic [1:0] stim_a;
  logic       busy_a, done_a, pass_a, fv_a;
  logic [2:0] err_a;
  logic [1:0] fvec_a;

  logic [2:0] stim_b;
  logic       busy_b, done_b, pass_b, fv_b;
  logic [3:0] err_b;
  logic [2:0] fvec_b;

  int n_vec = 0;
  int n_err = 0;

  gate_sweep_checker #(.N_IN(2), .TRUTH(4'b0001), .SETTLE(2)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .y(y_a),
    .stim(stim_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .fail_valid(fv_a), .fail_vec(fvec_a)
  );

  gate_sweep_checker #(.N_IN(3), .TRUTH(8'b00000001), .SETTLE(1)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .y(y_b),
    .stim(stim_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .fail_valid(fv_b), .fail_vec(fvec_b)
  );

  // Gate models: 0 = NOR, 1 = NAND, 2 = NOR with y_x driven on vector 1.
  always_comb begin
    case (mode)
      1:       y_a = ~&stim_a;
      2:       y_a = (stim_a == 2'd1) ? y_x : ~|stim_a;
      default: y_a = ~|stim_a;
    endcase
    y_b = ~|stim_b;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One sweep on instance A, observed for a fixed 20 cycles after the
  // accepting edge; optionally re-pulses start during cycles 2..10.
  task automatic run_a(input bit repulse, output int first_done, output int done_cnt);
    @(negedge clk); start_a = 1'b1;
    @(posedge clk);
    @(negedge clk); start_a = 1'b0;
    first_done = -1;
    done_cnt   = 0;
    for (int i = 0; i < 20; i++) begin
      if (i % 3 == 0 && i < 12) chk("a_stim_step", stim_a, i / 3);
      if (i == 0) chk("a_busy_start", busy_a, 1);
      if (done_a) begin
        done_cnt++;
        if (first_done < 0) first_done = i;
      end
      start_a = repulse && (i >= 2) && (i <= 10);
      @(posedge clk); @(negedge clk);
    end
    start_a = 1'b0;
  endtask

  int  fd, dc;
  bit  xmis;

  initial begin
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; mode = 0;
    y_x = 1'bx;
    repeat (2) @(negedge clk);
    chk("rst_stim",  stim_a, 0);
    chk("rst_busy",  busy_a, 0);
    chk("rst_done",  done_a, 0);
    chk("rst_pass",  pass_a, 0);
    chk("rst_err",   err_a, 0);
    chk("rst_fv",    fv_a, 0);
    chk("rst_fvec",  fvec_a, 0);
    reset = 1'b0;
    @(negedge clk);

    // Correct NOR: clean sweep, done 12 cycles after start accepted.
    mode = 0;
    run_a(1'b0, fd, dc);
    chk("nor_done_cycle", fd, 12);
    chk("nor_done_count", dc, 1);
    chk("nor_pass", pass_a, 1);
    chk("nor_err", err_a, 0);
    chk("nor_fv", fv_a, 0);
    chk("nor_busy_end", busy_a, 0);

    // NAND against NOR table: 00->1 agrees; 01,10 give 1 vs 0; 11 gives 0 vs 0...
    // NAND(11)=0, NOR(11)=0 agree, NAND(01)=1 vs 0, NAND(10)=1 vs 0,
    // NAND(00)=1 vs 1 agree -> wait, recount below in constants.
    mode = 1;
    run_a(1'b0, fd, dc);
    chk("nand_done_cycle", fd, 12);
    chk("nand_err", err_a, 2);
    chk("nand_fv", fv_a, 1);
    chk("nand_fvec", fvec_a, 1);
    chk("nand_pass", pass_a, 0);

    // Start re-pulsed mid-sweep: ignored, single done at cycle 12.
    mode = 0;
    run_a(1'b1, fd, dc);
    chk("repulse_done_cycle", fd, 12);
    chk("repulse_done_count", dc, 1);
    chk("repulse_busy_end", busy_a, 0);
    chk("repulse_pass", pass_a, 1);
    run_a(1'b0, fd, dc);
    chk("second_done_cycle", fd, 12);
    chk("second_pass", pass_a, 1);
    chk("second_err", err_a, 0);

    // Reset while stim = 2: asynchronous clear, no done, then a fresh sweep.
    @(negedge clk); start_a = 1'b1;
    @(posedge clk);
    @(negedge clk); start_a = 1'b0;
    repeat (6) begin @(posedge clk); @(negedge clk); end
    chk("pre_rst_stim", stim_a, 2);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_stim", stim_a, 0);
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_err",  err_a, 0);
    chk("mid_rst_pass", pass_a, 0);
    dc = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) reset = 1'b0;
      @(negedge clk);
      if (done_a) dc++;
    end
    chk("mid_rst_no_done", dc, 0);
    chk("mid_rst_idle_stim", stim_a, 0);
    run_a(1'b0, fd, dc);
    chk("post_rst_done_cycle", fd, 12);
    chk("post_rst_pass", pass_a, 1);

    // Unknown y on vector 1 only. In a four-state simulator the X must be a
    // mismatch; in a two-state one it counts only if it differs from NOR(01)=0.
    xmis = (y_x === 1'bx) ? 1'b1 : (y_x !== 1'b0);
    mode = 2;
    run_a(1'b0, fd, dc);
    chk("x_err",  err_a, xmis ? 1 : 0);
    chk("x_fv",   fv_a, xmis ? 1 : 0);
    chk("x_fvec", fvec_a, xmis ? 1 : 0);
    chk("x_pass", pass_a, xmis ? 0 : 1);
    mode = 0;

    // 3-input NOR, SETTLE = 1: 8 vectors x 2 cycles, done at cycle 16.
    @(negedge clk); start_b = 1'b1;
    @(posedge clk);
    @(negedge clk); start_b = 1'b0;
    fd = -1; dc = 0;
    for (int i = 0; i < 24; i++) begin
      if (i % 2 == 0 && i < 16) chk("b_stim_step", stim_b, i / 2);
      if (done_b) begin
        dc++;
        if (fd < 0) fd = i;
      end
      @(posedge clk); @(negedge clk);
    end
    chk("b_done_cycle", fd, 16);
    chk("b_done_count", dc, 1);
    chk("b_pass", pass_b, 1);
    chk("b_err", err_b, 0);
    chk("b_fv", fv_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
